// File: rtl/qs_spi_pkg.sv
// Shared definitions for the SPI command controller: frame/response layout,
// opcodes, FSM state encoding and small counter helpers.
package qs_spi_pkg;

  localparam int FRAME_W   = 32;
  localparam int PAYLOAD_W = 24;

  localparam int OP_MSB      = 31;
  localparam int OP_LSB      = 28;
  localparam int ADDR_MSB    = 27;
  localparam int ADDR_LSB    = 24;
  localparam int PAYLOAD_MSB = 23;
  localparam int PAYLOAD_LSB = 0;

  localparam int RESP_ERR_BIT = 27;
  localparam int RESP_OVR_BIT = 26;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_READ   = 4'h2;
  localparam logic [3:0] OP_STATUS = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_WRITE   = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RESPOND = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  addr;
    logic [23:0] payload;
  } frame_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic        err;
    logic        ovr;
    logic [1:0]  frame_lsb;
    logic [23:0] data;
  } resp_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_STATUS;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// SPI-frame and register-bus signals of the command controller.
// slave: the controller; master: SPI front end plus register file.
interface spi_cmd_ctrl_if #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_W   = 4
);
  logic [DATA_LEN-1:0] rx_data;
  logic                rx_ready;
  logic [DATA_LEN-1:0] tx_data;
  logic [ADDR_W-1:0]   reg_addr;
  logic                reg_wr_en;
  logic [23:0]         reg_wr_data;
  logic                reg_rd_en;
  logic [23:0]         reg_rd_data;

  modport slave (
    input  rx_data, rx_ready, reg_rd_data,
    output tx_data, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en
  );

  modport master (
    output rx_data, rx_ready, reg_rd_data,
    input  tx_data, reg_addr, reg_wr_en, reg_wr_data, reg_rd_en
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes received frames into register writes/reads
// and builds the response word shifted out during the next frame.
//
// state      | meaning
// IDLE       | waiting for a rx_ready rising edge
// DECODE     | frame captured; pulse reg_rd_en for READ
// WRITE      | reg_wr_en pulse with captured addr/payload
// RD_WAIT    | capture reg_rd_data
// RESPOND    | load tx_data, update counters
module spi_cmd_ctrl
  import qs_spi_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  spi_cmd_ctrl_if.slave  bus,
  output logic           busy
);

  state_e              state_q, state_d;
  frame_t              frame_q;
  resp_t               resp_d;
  logic [DATA_LEN-1:0] rx_word;
  logic [FRAME_W-1:0]  tx_q;
  logic [23:0]         rd_data_q;
  logic [7:0]          frame_cnt, err_cnt, ovr_cnt;
  logic                rx_ready_q, rx_rise, accept, drop;
  logic                ovr_pend;
  logic                wr_en, rd_en;

  assign rx_word = bus.rx_data;
  assign rx_rise = bus.rx_ready & ~rx_ready_q;
  assign accept  = rx_rise & (state_q == ST_IDLE);
  assign drop    = rx_rise & (state_q != ST_IDLE);

  assign busy            = (state_q != ST_IDLE);
  assign bus.tx_data     = tx_q;
  assign bus.reg_addr    = frame_q.addr[ADDR_W-1:0];
  assign bus.reg_wr_data = frame_q.payload;
  // Strobes are masked by rst so a reset landing in DECODE/WRITE never leaks a pulse.
  assign bus.reg_wr_en   = wr_en & ~rst;
  assign bus.reg_rd_en   = rd_en & ~rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and register strobes.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_DECODE;
      ST_DECODE: begin
        case (frame_q.opcode)
          OP_WRITE: state_d = ST_WRITE;
          OP_READ: begin
            rd_en   = 1'b1;
            state_d = ST_RD_WAIT;
          end
          default:  state_d = ST_RESPOND;
        endcase
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        state_d = ST_RESPOND;
      end
      ST_RD_WAIT: state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Response word; counters are taken before this frame's own update.
  always_comb begin
    resp_d           = '0;
    resp_d.opcode    = frame_q.opcode;
    resp_d.err       = ~op_legal(frame_q.opcode);
    resp_d.ovr       = ovr_pend;
    resp_d.frame_lsb = frame_cnt[1:0];
    case (frame_q.opcode)
      OP_WRITE:  resp_d.data = frame_q.payload;
      OP_READ:   resp_d.data = rd_data_q;
      OP_STATUS: resp_d.data = {frame_cnt, err_cnt, ovr_cnt};
      default:   resp_d.data = '0;
    endcase
  end

  // Frame capture, read capture, counters and tx register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Previous rx_ready resets high so a level still present after reset is not taken as an edge.
      rx_ready_q <= 1'b1;
      frame_q    <= '0;
      rd_data_q  <= '0;
      tx_q       <= '0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
      ovr_cnt    <= '0;
      ovr_pend   <= 1'b0;
    end else begin
      rx_ready_q <= bus.rx_ready;
      if (accept) frame_q <= frame_t'(rx_word);
      if (state_q == ST_RD_WAIT) rd_data_q <= bus.reg_rd_data;
      if (drop) ovr_cnt <= sat_inc(ovr_cnt);
      if (state_q == ST_RESPOND) begin
        tx_q     <= resp_d;
        // A drop in this very cycle belongs to the following response.
        ovr_pend <= drop;
        if (op_legal(frame_q.opcode)) frame_cnt <= frame_cnt + 8'd1;
        else                          err_cnt   <= sat_inc(err_cnt);
      end else if (drop) begin
        ovr_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: stimulus pushes expected responses and
// strobes; negedge monitors pop and compare as the DUT presents them.
module tb_spi_cmd_ctrl;

  typedef struct {
    logic [31:0] tx;
    int          issue;
  } exp_tx_t;

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [23:0] data;
  } exp_st_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_tx_t txq[$];
  exp_st_t sq[$];
  logic [23:0] rf [16];

  logic [7:0] fc_m, ec_m, oc_m;
  bit         ovr_m;

  logic        busy_d = 1'b0;
  logic [31:0] tx_prev = '0;

  spi_cmd_ctrl_if #(.DATA_LEN(32), .ADDR_W(4)) bus ();

  spi_cmd_ctrl #(.DATA_LEN(32), .ADDR_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register-file responder: read data appears one clock after reg_rd_en.
  initial begin
    logic [3:0] a;
    bus.reg_rd_data = 24'hBADBAD;
    forever begin
      @(negedge clk);
      if (bus.reg_rd_en) begin
        a = bus.reg_addr;
        @(posedge clk); #1 bus.reg_rd_data = rf[a];
        @(posedge clk); #1 bus.reg_rd_data = 24'hBADBAD;
      end
    end
  end

  // Monitor: responses on busy falling, strobes whenever asserted.
  always @(negedge clk) begin
    exp_tx_t e;
    exp_st_t s;
    if (!rst) begin
      if (busy_d && !busy) begin
        if (txq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_unexpected: got %h want none", bus.tx_data);
        end else begin
          e = txq.pop_front();
          chk("tx_data", bus.tx_data, e.tx);
          n_tests++;
          if (cyc - e.issue > 5) begin
            n_fail++;
            $display("FAIL tx_latency: got %0d want <=5 cycles", cyc - e.issue);
          end
        end
      end else if (bus.tx_data !== tx_prev) begin
        n_tests++; n_fail++;
        $display("FAIL tx_stable: got %h want %h", bus.tx_data, tx_prev);
      end
    end
    if (bus.reg_wr_en || bus.reg_rd_en) begin
      chk("strobe_excl", {30'd0, bus.reg_wr_en, bus.reg_rd_en} & 32'(bus.reg_wr_en & bus.reg_rd_en), 32'd0);
      if (sq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL strobe_unexpected: got wr=%b rd=%b want none", bus.reg_wr_en, bus.reg_rd_en);
      end else begin
        s = sq.pop_front();
        chk("strobe_kind", {31'd0, bus.reg_wr_en}, {31'd0, s.is_wr});
        chk("reg_addr", {28'd0, bus.reg_addr}, {28'd0, s.addr});
        if (s.is_wr) chk("reg_wr_data", {8'd0, bus.reg_wr_data}, {8'd0, s.data});
      end
    end
    busy_d  = busy;
    tx_prev = bus.tx_data;
  end

  task automatic model_reset();
    fc_m = 8'd0; ec_m = 8'd0; oc_m = 8'd0; ovr_m = 1'b0;
  endtask

  task automatic model_drop();
    oc_m  = (oc_m == 8'hFF) ? oc_m : oc_m + 8'd1;
    ovr_m = 1'b1;
  endtask

  // Pushes the expected response (hand value or model value) and strobes.
  task automatic push_expect(input logic [31:0] w, input bit hand, input logic [31:0] hv);
    logic [3:0]  op, a;
    logic [23:0] d;
    bit          legal;
    exp_tx_t     e;
    exp_st_t     s;
    op = w[31:28]; a = w[27:24]; legal = (op < 4'h4);
    case (op)
      4'h1:    d = w[23:0];
      4'h2:    d = rf[a];
      4'h3:    d = {fc_m, ec_m, oc_m};
      default: d = 24'd0;
    endcase
    e.tx    = hand ? hv : {op, ~legal, ovr_m, fc_m[1:0], d};
    e.issue = cyc;
    txq.push_back(e);
    if (op == 4'h1) begin s.is_wr = 1'b1; s.addr = a; s.data = w[23:0]; sq.push_back(s); end
    if (op == 4'h2) begin s.is_wr = 1'b0; s.addr = a; s.data = 24'd0;   sq.push_back(s); end
    ovr_m = 1'b0;
    if (legal) fc_m = fc_m + 8'd1;
    else       ec_m = (ec_m == 8'hFF) ? ec_m : ec_m + 8'd1;
  endtask

  task automatic issue(input logic [31:0] w, input bit hand, input logic [31:0] hv);
    @(posedge clk); #1;
    push_expect(w, hand, hv);
    bus.rx_data  = w;
    bus.rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.rx_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_data  = '0;
    for (int i = 0; i < 16; i++) rf[i] = 24'h0F0F00 + 24'(i);
    rf[5]  = 24'h123456;
    rf[10] = 24'hA5A5A5;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_data", bus.tx_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobes", {30'd0, bus.reg_wr_en, bus.reg_rd_en}, 32'd0);
    chk("rst_reg_addr", {28'd0, bus.reg_addr}, 32'd0);
    chk("rst_wr_data", {8'd0, bus.reg_wr_data}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    issue(32'h1300ABCD, 1, 32'h1000ABCD);
    issue(32'h25000000, 1, 32'h21123456);
    issue(32'h7A5A5A5A, 1, 32'h7A000000);
    issue(32'h30000000, 1, 32'h32020100);
    issue(32'h0FFFFFFF, 1, 32'h03000000);

    // Second rising edge while the first frame is still executing.
    @(posedge clk); #1;
    model_drop();
    push_expect(32'h1C00BEEF, 1, 32'h1400BEEF);
    bus.rx_data = 32'h1C00BEEF; bus.rx_ready = 1'b1;
    @(posedge clk); #1 bus.rx_ready = 1'b0;
    @(posedge clk); #1 bus.rx_data = 32'h1D001111; bus.rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    issue(32'h30000000, 1, 32'h31050101);

    // Reset while in RD_WAIT with rx_ready held high.
    @(posedge clk); #1;
    bus.rx_data = 32'h25000000; bus.rx_ready = 1'b1;
    sq.push_back('{is_wr: 1'b0, addr: 4'h5, data: 24'd0});
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_tx_data", bus.tx_data, 32'd0);
    chk("abort_strobes", {30'd0, bus.reg_wr_en, bus.reg_rd_en}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("held_rx_ready_idle", {31'd0, busy}, 32'd0);
    end
    bus.rx_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 256; i++) issue(32'h00000000, 0, 32'd0);
    issue(32'h30000000, 1, 32'h30000000);
    for (int i = 0; i < 300; i++) issue(32'hC0000000 | 32'(i), 0, 32'd0);
    issue(32'h30000000, 1, 32'h3101FF00);
    issue(32'h2A000000, 1, 32'h22A5A5A5);

    for (int i = 0; i < 100 && (txq.size() != 0 || sq.size() != 0); i++) @(posedge clk);
    if (txq.size() != 0 || sq.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: got %0d responses %0d strobes pending want 0", txq.size(), sq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
